// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_NOP    = 7'b0010011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } req_state_e;

  // Opcode fed back to the PC sequencer; a bubble looks like a NOP.
  function automatic logic [6:0] fetch_op(input logic vld, input logic [6:0] opcode);
    return vld ? opcode : OP_NOP;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO with clear; used for the fetch queue and the request address tags.
module if_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0]
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  T                       i_wdata,
  input  logic                   i_pop,
  output T                       o_rdata,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && !i_clr;
  assign w_pop  = i_pop && !i_clr && (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (w_push && (r_count == CW'(DEPTH))) |-> i_pop);

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: credit-limited word requests, in-order response queue, redirect flush.
// Optional misaligned-PC trap enabled by defining IF_MISALIGN_TRAP_EN.
module if_fetch
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [XLEN-1:0] IP,
  input  logic            FLUSH,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            ID_valid,
  input  logic            ID_ready,
  output logic [XLEN-1:0] ID_instr,
  output logic [XLEN-1:0] ID_pc,
  output logic [6:0]      OP,
  output logic            fetch_fault
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  req_state_e      r_state;
  req_state_e      w_state_nxt;
  logic            w_req_valid;
  logic [XLEN-1:0] r_addr;
  logic [CW-1:0]   r_out_cnt;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   w_q_count;
  logic [CW-1:0]   w_tag_count;
  logic            w_credit;
  logic            w_misalign;
  logic            w_fault;
  logic            w_sample;
  logic            w_accept;
  logic            w_tag_push;
  logic            w_rsp_drop;
  logic            w_rsp_live;
  logic            w_push;
  logic            w_pop;
  logic            w_q_empty;
  logic            w_tag_empty;
  logic [XLEN-1:0] w_tag;
  fetch_entry_t    w_q_wdata;
  fetch_entry_t    w_head;

`ifdef IF_MISALIGN_TRAP_EN
  logic r_fault;

  assign w_misalign = (IP[1:0] != 2'b00);

  // Sticky until the redirect that replaces the bad PC.
  always_ff @(posedge CLK) begin
    if (!RESET || FLUSH) r_fault <= 1'b0;
    else if ((r_state == IDLE) && w_credit && w_misalign) r_fault <= 1'b1;
  end

  assign w_fault = r_fault;
`else
  logic w_unused_ip_lo;

  assign w_unused_ip_lo = ^IP[1:0];
  assign w_misalign     = 1'b0;
  assign w_fault        = 1'b0;
`endif

  // Every accepted request owns a queue slot, so a response can never find the queue full.
  assign w_credit = (SW'(r_out_cnt) + SW'(w_q_count)) < SW'(DEPTH);
  assign w_sample = (r_state == IDLE) && w_credit && !FLUSH && !w_fault && !w_misalign;

  always_ff @(posedge CLK) begin
    if (!RESET) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_valid = 1'b0;
    case (r_state)
      IDLE: if (w_sample) w_state_nxt = REQ;
      REQ: begin
        w_req_valid = 1'b1;
        if (imem_req_ready || FLUSH) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET)        r_addr <= '0;
    else if (w_sample) r_addr <= {IP[XLEN-1:2], 2'b00};
  end

  assign w_accept   = w_req_valid && imem_req_ready;
  assign w_tag_push = w_accept && !FLUSH;
  assign w_rsp_drop = imem_rsp_valid && (r_drop_cnt != '0);
  assign w_rsp_live = imem_rsp_valid && (r_drop_cnt == '0);
  assign w_push     = w_rsp_live && !FLUSH;

  // On redirect, everything still owed by memory (even a request accepted this cycle) becomes a drop.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (FLUSH) begin
      r_out_cnt  <= '0;
      r_drop_cnt <= r_drop_cnt - CW'(w_rsp_drop) + r_out_cnt + CW'(w_accept) - CW'(w_rsp_live);
    end else begin
      r_out_cnt  <= r_out_cnt + CW'(w_accept) - CW'(w_rsp_live);
      r_drop_cnt <= r_drop_cnt - CW'(w_rsp_drop);
    end
  end

  if_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_tag_fifo (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_clr   (FLUSH),
    .i_push  (w_tag_push),
    .i_wdata (r_addr),
    .i_pop   (w_push),
    .o_rdata (w_tag),
    .o_empty (w_tag_empty),
    .o_count (w_tag_count)
  );

  assign w_q_wdata.pc    = w_tag;
  assign w_q_wdata.instr = imem_rsp_data;
  assign w_pop           = ID_valid && ID_ready;

  if_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_queue (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_clr   (FLUSH),
    .i_push  (w_push),
    .i_wdata (w_q_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  a_tags_track_outstanding: assert property (@(posedge CLK) disable iff (!RESET)
    w_tag_count == r_out_cnt);
  a_tag_present: assert property (@(posedge CLK) disable iff (!RESET)
    w_push |-> !w_tag_empty);

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_addr;
  assign ID_valid       = !w_q_empty;
  assign ID_instr       = ID_valid ? w_head.instr : '0;
  assign ID_pc          = ID_valid ? w_head.pc : '0;
  assign OP             = fetch_op(ID_valid, w_head.instr[6:0]);
  assign fetch_fault    = w_fault;

endmodule
